// File: rtl/sparse_coo_encoder_if.sv
// Dense-pixel input and COO-triplet output handshakes of the sparse encoder.
interface sparse_coo_encoder_if #(
  parameter int unsigned wordLength = 8
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [wordLength-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [wordLength-1:0] out_value;
  logic [wordLength-1:0] out_col;
  logic [wordLength-1:0] out_row;

  // Producer of pixels / consumer of triplets (activation side and sparse buffer)
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_value, out_col, out_row
  );

  // The encoder itself
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_value, out_col, out_row
  );
endinterface

// File: rtl/sparse_coo_encoder.sv
// Dense raster feature map -> COO (value, col, row) triplet stream with a
// non-zero count reported at frame end.
module sparse_coo_encoder #(
  parameter int unsigned dataRowNum       = 28,
  parameter int unsigned wordLength       = 8,
  parameter int unsigned doublewordLength = 16,
  parameter int unsigned fifoDepth        = 4
) (
  input  logic                        clk,
  input  logic                        irst_n,
  input  logic                        start,
  sparse_coo_encoder_if.slave         bus,
  output logic [doublewordLength-1:0] valid_num,
  output logic                        frame_done,
  output logic                        busy
);

  localparam int unsigned PTR_W = $clog2(fifoDepth);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [wordLength-1:0] LAST_IDX = wordLength'(dataRowNum - 1);
  localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(fifoDepth);

  // Parameter sanity: the nnz counter must hold a full frame, FIFO pointers must wrap naturally
  if ((longint'(dataRowNum) * longint'(dataRowNum)) >= (longint'(1) << doublewordLength)) begin : g_nnz_width_check
    $error("doublewordLength too narrow for dataRowNum^2 non-zero pixels");
  end
  if ((fifoDepth < 2) || ((fifoDepth & (fifoDepth - 1)) != 0)) begin : g_fifo_depth_check
    $error("fifoDepth must be a power of 2 and at least 2");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [wordLength-1:0] value;
    logic [wordLength-1:0] col;
    logic [wordLength-1:0] row;
  } triplet_t;

  state_t                      state;
  state_t                      state_nxt_c;
  logic [wordLength-1:0]       col;
  logic [wordLength-1:0]       row;
  logic [doublewordLength-1:0] nnz;
  logic                        in_ready_q;
  logic                        out_valid_q;
  triplet_t                    mem [fifoDepth];
  logic [PTR_W-1:0]            wr_ptr;
  logic [PTR_W-1:0]            rd_ptr;
  logic [CNT_W-1:0]            count;
  logic [CNT_W-1:0]            count_nxt_c;
  logic                        accept_c;
  logic                        push_c;
  logic                        pop_c;
  logic                        last_px_c;

  // Handshake qualification, FIFO occupancy look-ahead and next-state decode
  always_comb begin
    accept_c    = (state == RUN) && bus.in_valid && in_ready_q;
    push_c      = accept_c && (|bus.in_data);
    pop_c       = out_valid_q && bus.out_ready;
    last_px_c   = (col == LAST_IDX) && (row == LAST_IDX);
    count_nxt_c = count + CNT_W'(push_c) - CNT_W'(pop_c);
    state_nxt_c = state;
    case (state)
      IDLE:    if (start) state_nxt_c = RUN;
      RUN:     if (accept_c && last_px_c) state_nxt_c = DRAIN;
      DRAIN:   if (count_nxt_c == '0) state_nxt_c = DONE;
      DONE:    state_nxt_c = IDLE;
      default: state_nxt_c = IDLE;
    endcase
  end

  // State, raster counters, triplet FIFO and registered status outputs
  always_ff @(posedge clk or negedge irst_n) begin
    if (!irst_n) begin
      state       <= IDLE;
      col         <= '0;
      row         <= '0;
      nnz         <= '0;
      valid_num   <= '0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      for (int i = 0; i < int'(fifoDepth); i++) begin
        mem[i] <= '0;
      end
    end else begin
      state       <= state_nxt_c;
      busy        <= (state_nxt_c != IDLE);
      frame_done  <= (state_nxt_c == DONE);
      // in_ready looks only at occupancy, so it never depends on out_ready combinationally
      in_ready_q  <= (state_nxt_c == RUN) && (count_nxt_c != FULL_CNT);
      out_valid_q <= (count_nxt_c != '0);
      count       <= count_nxt_c;

      if (push_c) begin
        mem[wr_ptr] <= '{value: bus.in_data, col: col, row: row};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end

      if ((state == IDLE) && start) begin
        col <= '0;
        row <= '0;
        nnz <= '0;
      end

      if (accept_c) begin
        if (push_c) begin
          nnz <= nnz + doublewordLength'(1);
        end
        // Counters freeze on the last pixel of the frame
        if (!last_px_c) begin
          if (col == LAST_IDX) begin
            col <= '0;
            row <= row + wordLength'(1);
          end else begin
            col <= col + wordLength'(1);
          end
        end
      end

      if ((state == DRAIN) && (state_nxt_c == DONE)) begin
        valid_num <= nnz;
      end
    end
  end

  // Head of the FIFO drives the triplet outputs
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_value = mem[rd_ptr].value;
  assign bus.out_col   = mem[rd_ptr].col;
  assign bus.out_row   = mem[rd_ptr].row;

endmodule
